// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU core definitions
// Purpose: common constants for the pipeline and the stage action decode enum.
// Ports: none (package).
package cpu_pkg;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  // What a pipeline register does at the next clock edge.
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_BUBBLE  = 3'd2,
    ACT_ADVANCE = 3'd3,
    ACT_HOLD    = 3'd4
  } stage_action_e;

endpackage

// File: rtl/stage_ctl.sv
// rtl/stage_ctl.sv - stage boundary action decode
// Purpose: combinational priority decode of reset, flush and the stall bits
//   on both sides of a stage boundary into one stage_action_e.
// Ports:
//   rst     in  1  synchronous active-high reset request
//   flush   in  1  exception/branch flush
//   up_stop in  1  upstream stage stalled
//   dn_stop in  1  downstream stage stalled
//   action  out    decoded action for this edge
module stage_ctl
  import cpu_pkg::*;
(
  input  logic          rst,
  input  logic          flush,
  input  logic          up_stop,
  input  logic          dn_stop,
  output stage_action_e action
);

  always_comb begin
    action = ACT_HOLD;
    if (rst == RstEnable)
      action = ACT_RESET;
    else if (flush)
      action = ACT_FLUSH;
    else if (up_stop == Stop && dn_stop == NoStop)
      action = ACT_BUBBLE;
    else if (up_stop == NoStop)
      // Also covers the illegal !up_stop && dn_stop case: the op moves on.
      action = ACT_ADVANCE;
    else
      action = ACT_HOLD;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register
// Purpose: latches the register-write payload between two pipeline stages,
//   inserts bubbles, honours flush, counts bubbles and carries multi-cycle
//   op state (accumulator + step) back to the upstream stage while stalled.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   stall [STALL_W]                   controller stall vector, 1 = stop
//   flush                             exception/branch flush
//   in_valid/in_wreg/in_whilo         upstream valid and write enables
//   in_wd [ADDR_W]                    destination register
//   in_wdata/in_hi/in_lo [DATA_W]     result payload
//   scr_i [SCR_W], cnt_i [CNT_W]      multi-cycle partial result and step
//   out_*                             registered payload
//   scr_o, cnt_o                      carried state fed back upstream
//   bubble_cnt [BCNT_W]               saturating bubble cycle count
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int SCR_W     = 64,
  parameter int CNT_W     = 2,
  parameter int BCNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_wreg,
  input  logic               in_whilo,
  input  logic [ADDR_W-1:0]  in_wd,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [DATA_W-1:0]  in_hi,
  input  logic [DATA_W-1:0]  in_lo,
  input  logic [SCR_W-1:0]   scr_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               out_valid,
  output logic               out_wreg,
  output logic               out_whilo,
  output logic [ADDR_W-1:0]  out_wd,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [DATA_W-1:0]  out_hi,
  output logic [DATA_W-1:0]  out_lo,
  output logic [SCR_W-1:0]   scr_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [BCNT_W-1:0]  bubble_cnt
);

  logic          up_stop;
  logic          dn_stop;
  logic          unused_stall;
  stage_action_e action;

  assign up_stop = stall[STAGE_IDX];

  // The last stage has no downstream stall bit; never index past the vector.
  generate
    if (STAGE_IDX >= STALL_W - 1) begin : g_last
      assign dn_stop = NoStop;
    end else begin : g_mid
      assign dn_stop = stall[STAGE_IDX+1];
    end
  endgenerate

  // Only two bits of the shared stall vector belong to this boundary.
  assign unused_stall = ^stall;

  stage_ctl u_ctl (
    .rst     (rst),
    .flush   (flush),
    .up_stop (up_stop),
    .dn_stop (dn_stop),
    .action  (action)
  );

  always_ff @(posedge clk) begin
    unique case (action)
      ACT_RESET: begin
        out_valid  <= 1'b0;
        out_wreg   <= 1'b0;
        out_whilo  <= 1'b0;
        out_wd     <= ADDR_W'(NOPRegAddr);
        out_wdata  <= DATA_W'(ZeroWord);
        out_hi     <= DATA_W'(ZeroWord);
        out_lo     <= DATA_W'(ZeroWord);
        scr_o      <= '0;
        cnt_o      <= '0;
        bubble_cnt <= '0;
      end
      ACT_FLUSH: begin
        // Cancels any in-flight multi-cycle op; bubble count is untouched.
        out_valid  <= 1'b0;
        out_wreg   <= 1'b0;
        out_whilo  <= 1'b0;
        out_wd     <= ADDR_W'(NOPRegAddr);
        out_wdata  <= DATA_W'(ZeroWord);
        out_hi     <= DATA_W'(ZeroWord);
        out_lo     <= DATA_W'(ZeroWord);
        scr_o      <= '0;
        cnt_o      <= '0;
      end
      ACT_BUBBLE: begin
        out_valid  <= 1'b0;
        out_wreg   <= 1'b0;
        out_whilo  <= 1'b0;
        out_wd     <= ADDR_W'(NOPRegAddr);
        out_wdata  <= DATA_W'(ZeroWord);
        out_hi     <= DATA_W'(ZeroWord);
        out_lo     <= DATA_W'(ZeroWord);
        scr_o      <= scr_i;
        cnt_o      <= cnt_i;
        if (bubble_cnt != '1)
          bubble_cnt <= bubble_cnt + BCNT_W'(1);
      end
      ACT_ADVANCE: begin
        // Write enables are meaningless without a valid instruction.
        out_valid  <= in_valid;
        out_wreg   <= in_valid & in_wreg;
        out_whilo  <= in_valid & in_whilo;
        out_wd     <= in_wd;
        out_wdata  <= in_wdata;
        out_hi     <= in_hi;
        out_lo     <= in_lo;
        scr_o      <= '0;
        cnt_o      <= '0;
      end
      ACT_HOLD: begin
        scr_o      <= scr_i;
        cnt_o      <= cnt_i;
      end
      default: begin
        scr_o      <= '0;
        cnt_o      <= '0;
      end
    endcase
  end

  // The controller must never stall downstream while upstream advances.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(up_stop == NoStop && dn_stop == Stop));
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid, in_wreg, in_whilo;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata, in_hi, in_lo;
  logic [63:0] scr_i;
  logic [1:0]  cnt_i;

  always #5 clk = ~clk;

  // Instance A: defaults. Instance B: 2-bit bubble counter. Instance C: last stage.
  logic        a_valid, a_wreg, a_whilo, b_valid, b_wreg, b_whilo, c_valid, c_wreg, c_whilo;
  logic [4:0]  a_wd, b_wd, c_wd;
  logic [31:0] a_wdata, a_hi, a_lo, b_wdata, b_hi, b_lo, c_wdata, c_hi, c_lo;
  logic [63:0] a_scr, b_scr, c_scr;
  logic [1:0]  a_cnt, b_cnt, c_cnt;
  logic [15:0] a_bub, c_bub;
  logic [1:0]  b_bub;

  pipe_stage_reg dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_whilo(in_whilo), .in_wd(in_wd),
    .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo), .scr_i(scr_i), .cnt_i(cnt_i),
    .out_valid(a_valid), .out_wreg(a_wreg), .out_whilo(a_whilo), .out_wd(a_wd),
    .out_wdata(a_wdata), .out_hi(a_hi), .out_lo(a_lo), .scr_o(a_scr), .cnt_o(a_cnt),
    .bubble_cnt(a_bub)
  );

  pipe_stage_reg #(.BCNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_whilo(in_whilo), .in_wd(in_wd),
    .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo), .scr_i(scr_i), .cnt_i(cnt_i),
    .out_valid(b_valid), .out_wreg(b_wreg), .out_whilo(b_whilo), .out_wd(b_wd),
    .out_wdata(b_wdata), .out_hi(b_hi), .out_lo(b_lo), .scr_o(b_scr), .cnt_o(b_cnt),
    .bubble_cnt(b_bub)
  );

  pipe_stage_reg #(.STAGE_IDX(5)) dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_whilo(in_whilo), .in_wd(in_wd),
    .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo), .scr_i(scr_i), .cnt_i(cnt_i),
    .out_valid(c_valid), .out_wreg(c_wreg), .out_whilo(c_whilo), .out_wd(c_wd),
    .out_wdata(c_wdata), .out_hi(c_hi), .out_lo(c_lo), .scr_o(c_scr), .cnt_o(c_cnt),
    .bubble_cnt(c_bub)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: what each stage register should hold after an edge.
  typedef struct {
    bit          valid, wreg, whilo;
    bit [4:0]    wd;
    bit [31:0]   wdata, hi, lo;
    bit [63:0]   scr;
    bit [1:0]    cnt;
    int unsigned bub;
  } mstate_t;

  mstate_t ma, mb, mc;

  function automatic mstate_t mstep(mstate_t m, int up_idx, int unsigned bub_max);
    mstate_t n = m;
    bit up = stall[up_idx];
    bit dn = (up_idx + 1 < 6) ? stall[up_idx+1] : 1'b0;
    bit nop = rst || flush || (up && !dn);
    if (nop) begin
      n.valid = 0; n.wreg = 0; n.whilo = 0; n.wd = 0; n.wdata = 0; n.hi = 0; n.lo = 0;
    end
    if (rst) begin
      n.scr = 0; n.cnt = 0; n.bub = 0;
    end else if (flush || !up) begin
      n.scr = 0; n.cnt = 0;
      if (!flush) begin
        n.valid = in_valid; n.wreg = in_valid && in_wreg; n.whilo = in_valid && in_whilo;
        n.wd = in_wd; n.wdata = in_wdata; n.hi = in_hi; n.lo = in_lo;
      end
    end else begin
      n.scr = scr_i; n.cnt = cnt_i;
      if (!dn && n.bub < bub_max) n.bub = n.bub + 1;
    end
    return n;
  endfunction

  task automatic cmp_inst(input string nm, input mstate_t m,
                          input logic v, input logic w, input logic wh, input logic [4:0] wd,
                          input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [63:0] scr, input logic [1:0] cnt, input logic [15:0] bub);
    check({nm, ".valid"}, 64'(v), 64'(m.valid));
    check({nm, ".wreg"},  64'(w), 64'(m.wreg));
    check({nm, ".whilo"}, 64'(wh), 64'(m.whilo));
    check({nm, ".wd"},    64'(wd), 64'(m.wd));
    check({nm, ".wdata"}, 64'(wdata), 64'(m.wdata));
    check({nm, ".hi"},    64'(hi), 64'(m.hi));
    check({nm, ".lo"},    64'(lo), 64'(m.lo));
    check({nm, ".scr"},   scr, m.scr);
    check({nm, ".cnt"},   64'(cnt), 64'(m.cnt));
    check({nm, ".bub"},   64'(bub), 64'(m.bub));
  endtask

  task automatic step();
    @(posedge clk);
    ma = mstep(ma, 3, 65535);
    mb = mstep(mb, 3, 3);
    mc = mstep(mc, 5, 65535);
    #1;
    cmp_inst("a", ma, a_valid, a_wreg, a_whilo, a_wd, a_wdata, a_hi, a_lo, a_scr, a_cnt, a_bub);
    cmp_inst("b", mb, b_valid, b_wreg, b_whilo, b_wd, b_wdata, b_hi, b_lo, b_scr, b_cnt, 16'(b_bub));
    cmp_inst("c", mc, c_valid, c_wreg, c_whilo, c_wd, c_wdata, c_hi, c_lo, c_scr, c_cnt, c_bub);
  endtask

  task automatic drive_random();
    logic [5:0] s;
    s = 6'($urandom_range(0, 63));
    if (!s[3]) s[4] = 1'b0;          // keep the controller legal for stage 3
    stall    = s;
    rst      = ($urandom_range(0, 49) == 0);
    flush    = ($urandom_range(0, 15) == 0);
    in_valid = 1'($urandom);
    in_wreg  = 1'($urandom);
    in_whilo = 1'($urandom);
    in_wd    = 5'($urandom);
    in_wdata = $urandom;
    in_hi    = $urandom;
    in_lo    = $urandom;
    scr_i    = {$urandom, $urandom};
    cnt_i    = 2'($urandom);
  endtask

  initial begin
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};

    // Reset with busy inputs.
    rst = 1; flush = 1; stall = 6'b011000;
    in_valid = 1; in_wreg = 1; in_whilo = 1; in_wd = 5'd7;
    in_wdata = 32'hFFFF_0001; in_hi = 32'h1; in_lo = 32'h2;
    scr_i = 64'hAAAA; cnt_i = 2'd3;
    step(); step();
    check("reset_bub", 64'(a_bub), 64'd0);
    check("reset_wd", 64'(a_wd), 64'd0);

    // Advance.
    rst = 0; flush = 0; stall = 6'b000000;
    in_wd = 5'd3; in_wdata = 32'hDEADBEEF; in_wreg = 1; in_valid = 1;
    step();
    check("adv_wdata", 64'(a_wdata), 64'hDEADBEEF);
    check("adv_cnt", 64'(a_cnt), 64'd0);

    // Advance with an invalid instruction drops the write enables.
    in_valid = 0;
    step();
    check("adv_inv_wreg", 64'(a_wreg), 64'd0);

    // Bubble, five cycles: 2-bit counter saturates.
    stall = 6'b001000; scr_i = 64'h1234; cnt_i = 2'd1; in_valid = 1;
    for (int i = 0; i < 5; i++) step();
    check("bub_scr", a_scr, 64'h1234);
    check("bub_cnt", 64'(a_cnt), 64'd1);
    check("bub_a5", 64'(a_bub), 64'd5);
    check("bub_sat", 64'(b_bub), 64'd3);

    // Hold after advancing 0x55.
    stall = 6'b000000; in_wdata = 32'h55;
    step();
    stall = 6'b011000; in_wdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      cnt_i = 2'(i);
      step();
      check("hold_wdata", 64'(a_wdata), 64'h55);
      check("hold_cnt", 64'(a_cnt), 64'(i));
    end

    // Flush during a multi-cycle op.
    stall = 6'b001000; cnt_i = 2'd1;
    step();
    flush = 1;
    step();
    check("flush_cnt", 64'(a_cnt), 64'd0);
    check("flush_scr", a_scr, 64'd0);
    check("flush_bub", 64'(a_bub), 64'd6);
    flush = 0;

    // Last-stage instance bubbles on its own bit.
    stall = 6'b100000; scr_i = 64'h7777; cnt_i = 2'd2;
    step();
    check("last_valid", 64'(c_valid), 64'd0);
    check("last_scr", c_scr, 64'h7777);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
